// File: rtl/io_bus_pkg.sv
// Shared types and constants for the IO bus arbiter,
// the IO peripheral block and the CPU IO path.
package io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } owner_t;

  localparam logic [31:0] BTN_BASE = 32'h8000_0000;
  localparam logic [31:0] LED_BASE = 32'h8000_0010;

  localparam logic [31:0] LED0_OFS = 32'd0;
  localparam logic [31:0] LED1_OFS = 32'd4;
  localparam logic [31:0] LED2_OFS = 32'd8;
  localparam logic [31:0] LED3_OFS = 32'd12;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

endpackage

// File: rtl/io_bus_if.sv
// Two request masters on one side, the IO peripheral
// on the other; slave is the arbiter's view.
interface io_bus_if;

  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m0_we;
  logic [3:0]  m0_be;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic        m1_we;
  logic [3:0]  m1_be;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;

  logic [31:0] io_addr;
  logic        io_we;
  logic [3:0]  io_be;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;

  modport slave (
    input  m0_req, m0_addr, m0_we, m0_be, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_addr, m1_we, m1_be, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output io_addr, io_we, io_be, io_wdata,
    input  io_rdata
  );

  modport master (
    output m0_req, m0_addr, m0_we, m0_be, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_addr, m1_we, m1_be, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  io_addr, io_we, io_be, io_wdata,
    output io_rdata
  );

endinterface

// File: rtl/io_bus_arbiter_rr_pick.sv
// Combinational 2-way chooser: round-robin on a tie
// when rr_en is set, otherwise master 0 wins.
module io_rr_pick
  import io_bus_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  input  logic       rr_en,
  output logic       valid,
  output owner_t     winner
);

  always_comb begin
    valid  = |req;
    winner = M0;
    unique case (1'b1)
      (req == 2'b11):
        winner = (rr_en && last_owner == M0) ? M1 : M0;
      (req == 2'b10):
        winner = M1;
      default:
        winner = M0;
    endcase
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Serialises single-beat transactions from two masters
// onto the IO peripheral: IDLE -> ISSUE -> WAIT.
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  io_bus_if.slave  bus
);

  state_t      state_q, state_d;
  owner_t      owner_q, last_q;
  txn_t        txn_q;
  txn_t        m0_txn, m1_txn;
  logic        gnt0_q, gnt1_q;
  logic        rv0_q, rv1_q;
  logic [31:0] rd0_q, rd1_q;
  logic        pick_valid;
  owner_t      pick_win;
  logic        accept;
  logic [31:0] cap;

  assign m0_txn = {bus.m0_addr, bus.m0_we,
                   bus.m0_be, bus.m0_wdata};
  assign m1_txn = {bus.m1_addr, bus.m1_we,
                   bus.m1_be, bus.m1_wdata};

  io_rr_pick u_pick (
    .req        ({bus.m1_req, bus.m0_req}),
    .last_owner (last_q),
    .rr_en      (RR_EN),
    .valid      (pick_valid),
    .winner     (pick_win)
  );

  assign accept = (state_q == IDLE) && pick_valid;
  // A completed write hands back zero, not stale bus data.
  assign cap = txn_q.we ? 32'h0 : bus.io_rdata;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= M0;
      last_q  <= M1;
      txn_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rd0_q   <= 32'h0;
      rd1_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      gnt0_q  <= accept && (pick_win == M0);
      gnt1_q  <= accept && (pick_win == M1);
      rv0_q   <= (state_q == WAIT) && (owner_q == M0);
      rv1_q   <= (state_q == WAIT) && (owner_q == M1);
      if (accept) begin
        txn_q   <= (pick_win == M1) ? m1_txn : m0_txn;
        owner_q <= pick_win;
        last_q  <= pick_win;
      end
      if (state_q == WAIT) begin
        if (owner_q == M0) rd0_q <= cap;
        else               rd1_q <= cap;
      end
    end
  end

  assign bus.m0_gnt    = gnt0_q;
  assign bus.m1_gnt    = gnt1_q;
  assign bus.m0_rvalid = rv0_q;
  assign bus.m1_rvalid = rv1_q;
  assign bus.m0_rdata  = rd0_q;
  assign bus.m1_rdata  = rd1_q;

  assign bus.io_addr  = txn_q.addr;
  assign bus.io_be    = txn_q.be;
  assign bus.io_wdata = txn_q.wdata;
  assign bus.io_we    = (state_q == ISSUE) && txn_q.we;

endmodule
